// File: rtl/stage_id_ctrl_pkg.sv
// Shared opcode constants, debug state type and operand-usage helpers for the ID stage.
package core_pkg;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {
    DBG_RUN    = 2'd0,
    DBG_DRAIN  = 2'd1,
    DBG_HALTED = 2'd2
  } dbg_state_e;

  // CSR-immediate SYSTEM forms (funct3 msb set) carry a uimm in the rs1 field.
  function automatic logic op_uses_rs1(input logic [4:0] op5, input logic f3_msb);
    return !(op5 == OPCODE_LUI || op5 == OPCODE_AUIPC || op5 == OPCODE_JAL ||
             (op5 == OPCODE_SYSTEM && f3_msb));
  endfunction

  function automatic logic op_uses_rs2(input logic [4:0] op5);
    return op5 == OPCODE_BRANCH || op5 == OPCODE_STORE || op5 == OPCODE_OP;
  endfunction

endpackage

// File: rtl/stage_id_ctrl_if.sv
// IF->ID and ID->EX handshake bundle; master is the ID stage, slave is its environment.
interface stage_id_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            if_vld;
  logic            if_rdy;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_ir;
  logic            if_c;
  logic            if_e;

  logic            id_vld;
  logic            id_rdy;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_ir;
  logic            id_c;
  logic            id_e;

  modport master (
    input  if_vld, if_pc, if_ir, if_c, if_e, id_rdy,
    output if_rdy, id_vld, id_pc, id_ir, id_c, id_e
  );

  modport slave (
    output if_vld, if_pc, if_ir, if_c, if_e, id_rdy,
    input  if_rdy, id_vld, id_pc, id_ir, id_c, id_e
  );

endinterface

// File: rtl/stage_id_ctrl_ld_scoreboard.sv
// FIFO of outstanding load destinations; lookups ignore the head entry while it retires.
module ld_scoreboard #(
  parameter int unsigned NOUT = 2,
  parameter int unsigned RIW  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [RIW-1:0]             push_idx,
  input  logic                       pop,
  input  logic [RIW-1:0]             q_idx1,
  input  logic [RIW-1:0]             q_idx2,
  output logic                       hit1,
  output logic                       hit2,
  output logic                       full,
  output logic [$clog2(NOUT+1)-1:0]  cnt,
  output logic                       err
);

  localparam int unsigned PW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int unsigned CW = $clog2(NOUT + 1);

  logic [RIW-1:0] idx_q [NOUT];
  logic [NOUT-1:0] vld_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic            pop_ok;
  logic            push_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NOUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop & (cnt_q != '0);
  assign full    = (cnt_q == CW'(NOUT));
  assign push_ok = push & (~full | pop_ok);
  assign cnt     = cnt_q;
  assign err     = err_q;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < NOUT; i++) begin
      if (vld_q[i] && !(pop_ok && head_q == PW'(i))) begin
        if (idx_q[i] == q_idx1) hit1 = 1'b1;
        if (idx_q[i] == q_idx2) hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < NOUT; i++) idx_q[i] <= '0;
    end else begin
      if (pop && !pop_ok) err_q <= 1'b1;
      if (pop_ok) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= wrap_inc(head_q);
      end
      // On full push+pop head==tail; the push write below wins the valid bit.
      if (push_ok) begin
        vld_q[tail_q] <= 1'b1;
        idx_q[tail_q] <= push_idx;
        tail_q        <= wrap_inc(tail_q);
      end
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/stage_id_ctrl.sv
// ID pipeline register with load-use interlock, jump flush and debug-halt drain control.
module stage_id_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  parameter int unsigned NOUT = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  stage_id_ctrl_if.master           pipe,
  input  logic                      flush,
  input  logic                      dbusif_done,
  input  logic                      dbusif_err,
  input  logic                      dm_haltreq,
  input  logic                      dm_resumereq,
  output logic                      halted,
  output logic [$clog2(NOUT+1)-1:0] sb_cnt,
  output logic                      sb_err
);

  localparam int unsigned RIW = $clog2(NREG);

  logic            id_vld_q;
  logic [XLEN-1:0] id_pc_q;
  logic [31:0]     id_ir_q;
  logic            id_c_q;
  logic            id_e_q;

  dbg_state_e state_q, state_d;

  logic [4:0]     op5;
  logic [RIW-1:0] rs1, rs2, rd;
  logic           uses_rs1, uses_rs2, is_load;
  logic           hit1, hit2, sb_full;
  logic           hazard, id_vld, fire_id, if_rdy, if_load;

  assign op5 = id_ir_q[6:2];
  assign rs1 = id_ir_q[15 +: RIW];
  assign rs2 = id_ir_q[20 +: RIW];
  assign rd  = id_ir_q[7 +: RIW];

  assign uses_rs1 = op_uses_rs1(op5, id_ir_q[14]);
  assign uses_rs2 = op_uses_rs2(op5);
  assign is_load  = (op5 == OPCODE_LOAD) && (rd != '0);

  ld_scoreboard #(
    .NOUT (NOUT),
    .RIW  (RIW)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fire_id & is_load),
    .push_idx (rd),
    .pop      (dbusif_done | dbusif_err),
    .q_idx1   (rs1),
    .q_idx2   (rs2),
    .hit1     (hit1),
    .hit2     (hit2),
    .full     (sb_full),
    .cnt      (sb_cnt),
    .err      (sb_err)
  );

  assign hazard = id_vld_q & ((uses_rs1 & (rs1 != '0) & hit1) |
                              (uses_rs2 & (rs2 != '0) & hit2) |
                              (is_load & sb_full));
  assign id_vld  = id_vld_q & ~hazard & ~flush;
  assign fire_id = id_vld & pipe.id_rdy;
  assign if_rdy  = ~flush & (state_q == DBG_RUN) & (~id_vld_q | fire_id);
  assign if_load = pipe.if_vld & if_rdy;

  assign pipe.if_rdy = if_rdy;
  assign pipe.id_vld = id_vld;
  assign pipe.id_pc  = id_pc_q;
  assign pipe.id_ir  = id_ir_q;
  assign pipe.id_c   = id_c_q;
  assign pipe.id_e   = id_e_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_vld_q <= 1'b0;
      id_pc_q  <= '0;
      id_ir_q  <= '0;
      id_c_q   <= 1'b0;
      id_e_q   <= 1'b0;
    end else begin
      if (flush) begin
        id_vld_q <= 1'b0;
      end else if (if_load) begin
        id_vld_q <= 1'b1;
        id_pc_q  <= pipe.if_pc;
        id_ir_q  <= pipe.if_ir;
        id_c_q   <= pipe.if_c;
        id_e_q   <= pipe.if_e;
      end else if (fire_id) begin
        id_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= DBG_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    halted  = (state_q == DBG_HALTED);
    unique case (state_q)
      DBG_RUN:    if (dm_haltreq) state_d = DBG_DRAIN;
      DBG_DRAIN:  if (!id_vld_q && sb_cnt == '0) state_d = DBG_HALTED;
      DBG_HALTED: if (dm_resumereq) state_d = DBG_RUN;
      default:    state_d = DBG_RUN;
    endcase
  end

endmodule

// File: tb/tb_stage_id_ctrl.sv
// Directed and randomized stimulus checked cycle-by-cycle against a queue-based model of the ID stage.
module tb_stage_id_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned NOUT = 2;
  localparam int unsigned CW   = $clog2(NOUT + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, flush, dbusif_done, dbusif_err, dm_haltreq, dm_resumereq;
  logic          halted, sb_err;
  logic [CW-1:0] sb_cnt;

  stage_id_ctrl_if #(.XLEN(XLEN)) pipe ();

  stage_id_ctrl #(.XLEN(XLEN), .NREG(NREG), .NOUT(NOUT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pipe         (pipe),
    .flush        (flush),
    .dbusif_done  (dbusif_done),
    .dbusif_err   (dbusif_err),
    .dm_haltreq   (dm_haltreq),
    .dm_resumereq (dm_resumereq),
    .halted       (halted),
    .sb_cnt       (sb_cnt),
    .sb_err       (sb_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: ID slot contents, outstanding load rds in issue order, debug mode.
  bit          m_vld;
  logic [31:0] m_pc, m_ir;
  bit          m_c, m_e, m_err;
  int          q[$];
  int          m_st;   // 0 run, 1 draining, 2 halted
  bit          acc;

  bit          d_rstn, d_vld, d_rdy, d_flush, d_done, d_err, d_halt, d_res, d_c, d_e;
  logic [31:0] d_pc, d_ir;

  localparam logic [6:0] OP_ADD = 7'b0110011, OP_LW  = 7'b0000011, OP_SW  = 7'b0100011,
                         OP_BR  = 7'b1100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_SYS = 7'b1110011, OP_IMM = 7'b0010011,
                         OP_JLR = 7'b1100111;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    logic [31:0] ir;
    ir = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
    return ir;
  endfunction

  function automatic bit reads_rs1(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    if (op == OP_LUI || op == OP_AUI || op == OP_JAL) return 1'b0;
    if (op == OP_SYS && ir[14]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit reads_rs2(input logic [31:0] ir);
    return ir[6:0] == OP_BR || ir[6:0] == OP_SW || ir[6:0] == OP_ADD;
  endfunction

  function automatic bit pending(input int r, input bit retiring);
    for (int i = 0; i < q.size(); i++)
      if (!(retiring && i == 0) && q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc();
    int rs1, rs2, rd;
    bit ld, ret, hz, ev, fire, er;
    @(negedge clk);
    rstn = d_rstn; flush = d_flush; dbusif_done = d_done; dbusif_err = d_err;
    dm_haltreq = d_halt; dm_resumereq = d_res;
    pipe.if_vld = d_vld; pipe.if_pc = d_pc; pipe.if_ir = d_ir; pipe.if_c = d_c; pipe.if_e = d_e;
    pipe.id_rdy = d_rdy;
    #1;
    rs1  = int'(m_ir[19:15]) % NREG;
    rs2  = int'(m_ir[24:20]) % NREG;
    rd   = int'(m_ir[11:7]) % NREG;
    ld   = (m_ir[6:0] == OP_LW) && rd != 0;
    ret  = (d_done || d_err) && q.size() > 0;
    hz   = m_vld && ((reads_rs1(m_ir) && rs1 != 0 && pending(rs1, ret)) ||
                     (reads_rs2(m_ir) && rs2 != 0 && pending(rs2, ret)) ||
                     (ld && q.size() == NOUT));
    ev   = m_vld && !hz && !d_flush;
    fire = ev && d_rdy;
    er   = !d_flush && m_st == 0 && (!m_vld || fire);
    chk("if_rdy", pipe.if_rdy, er);
    chk("id_vld", pipe.id_vld, ev);
    chk("id_pc", pipe.id_pc, m_pc);
    chk("id_ir", pipe.id_ir, m_ir);
    chk("id_ce", {pipe.id_c, pipe.id_e}, {m_c, m_e});
    chk("halted", halted, m_st == 2);
    chk("sb_cnt", sb_cnt, q.size());
    chk("sb_err", sb_err, m_err);
    @(posedge clk);
    acc = d_vld && er && d_rstn;
    if (!d_rstn) begin
      m_vld = 0; m_pc = '0; m_ir = '0; m_c = 0; m_e = 0; m_err = 0; m_st = 0;
      q.delete();
    end else begin
      case (m_st)
        0: if (d_halt) m_st = 1;
        1: if (!m_vld && q.size() == 0) m_st = 2;
        default: if (d_res) m_st = 0;
      endcase
      if (d_done || d_err) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (fire && ld) q.push_back(rd);
      if (d_flush) m_vld = 0;
      else if (d_vld && er) begin
        m_vld = 1; m_pc = d_pc; m_ir = d_ir; m_c = d_c; m_e = d_e;
      end else if (fire) m_vld = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic issue(input logic [31:0] ir);
    d_vld = 1; d_ir = ir; acc = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (acc) break;
    end
    chk("issue_accepted", acc, 1'b1);
    d_vld = 0; d_pc = d_pc + 32'd4;
  endtask

  task automatic drain();
    d_done = 1;
    for (int k = 0; k < 10; k++) begin
      if (q.size() == 0) break;
      cyc();
    end
    d_done = 0;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops [10];
    logic [31:0] ir;
    ops = '{OP_ADD, OP_LW, OP_LW, OP_SW, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_SYS, OP_IMM};
    ir = $urandom;
    if ($urandom_range(0, 9) == 0) ir[6:0] = OP_JLR;
    else ir[6:0] = ops[$urandom_range(0, 9)];
    ir[11:7]  = 5'($urandom_range(0, 7));
    ir[19:15] = 5'($urandom_range(0, 7));
    ir[24:20] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  initial begin
    d_rstn = 0; d_vld = 0; d_rdy = 1; d_flush = 0; d_done = 0; d_err = 0;
    d_halt = 0; d_res = 0; d_c = 0; d_e = 0; d_pc = '0; d_ir = '0;
    rstn = 0; flush = 0; dbusif_done = 0; dbusif_err = 0; dm_haltreq = 0; dm_resumereq = 0;
    pipe.if_vld = 0; pipe.if_pc = '0; pipe.if_ir = '0; pipe.if_c = 0; pipe.if_e = 0; pipe.id_rdy = 1;
    repeat (2) @(posedge clk);
    m_vld = 0; m_pc = '0; m_ir = '0; m_c = 0; m_e = 0; m_err = 0; m_st = 0; q.delete();
    d_rstn = 1;

    // back-to-back independent adds
    issue(mk(OP_ADD, 1, 2, 3));
    issue(mk(OP_ADD, 4, 2, 3));
    issue(mk(OP_ADD, 8, 9, 10));
    idle(2);

    // load-use stall released in the done cycle
    issue(mk(OP_LW, 5, 2, 0));
    issue(mk(OP_ADD, 6, 5, 7));
    idle(3);
    d_done = 1; cyc(); d_done = 0;
    idle(2);

    // three loads against a two-deep scoreboard
    issue(mk(OP_LW, 1, 0, 0));
    issue(mk(OP_LW, 2, 0, 0));
    issue(mk(OP_LW, 3, 0, 0));
    idle(3);
    d_done = 1; cyc(); d_done = 0;
    idle(2);
    drain();

    // flush with an offer pending and a load outstanding
    issue(mk(OP_LW, 3, 0, 0));
    issue(mk(OP_ADD, 1, 2, 4));
    d_flush = 1; d_vld = 1; d_pc = 32'h100; d_ir = mk(OP_ADD, 9, 1, 1); cyc();
    d_flush = 0; d_vld = 0; d_pc = 32'h200;
    idle(2);
    drain();

    // debug halt with one load outstanding
    issue(mk(OP_LW, 4, 0, 0));
    cyc();
    d_halt = 1; cyc(); d_halt = 0;
    d_vld = 1; d_ir = mk(OP_ADD, 1, 1, 1); idle(2); d_vld = 0;
    d_done = 1; cyc(); d_done = 0;
    idle(3);
    d_halt = 1; d_res = 1; cyc(); d_halt = 0; d_res = 0;
    issue(mk(OP_ADD, 7, 4, 4));

    // spurious retire, then a load to x0
    drain();
    d_done = 1; cyc(); d_done = 0;
    idle(2);
    d_err = 1; d_done = 1; cyc(); d_err = 0; d_done = 0;
    issue(mk(OP_LW, 0, 0, 0));
    idle(3);
    d_rstn = 0; idle(2); d_rstn = 1;

    for (int n = 0; n < 4000; n++) begin
      if (acc || !d_vld) begin
        d_ir = rand_ir(); d_pc = $urandom; d_c = 1'($urandom); d_e = 1'($urandom);
      end
      d_vld   = $urandom_range(0, 9) < 8;
      d_rdy   = $urandom_range(0, 9) < 8;
      d_flush = $urandom_range(0, 19) == 0;
      d_done  = $urandom_range(0, 9) < 3;
      d_err   = $urandom_range(0, 19) == 0;
      d_halt  = $urandom_range(0, 49) == 0;
      d_res   = $urandom_range(0, 9) == 0;
      d_rstn  = $urandom_range(0, 499) != 0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
